// File: rtl/spi_slave_four_byte.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_slave_four_byte                                          |
// | Description : Mode-0 SPI slave, 32-bit frames oversampled in the clk       |
// |               domain. It has a one-entry 24-bit response holding register. |
// |               Define SPI_MISO_TRISTATE_EN to float MISO while SS is high.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_slave_four_byte #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] TX_HDR_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SPI_SCK,
  input  logic        SPI_SS,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  output logic        wr_buffer_free,
  input  logic        wr_en,
  input  logic [23:0] wr_data,
  output logic        rd_data_available,
  input  logic        rd_ack,
  output logic [31:0] rd_data,
  output logic [3:0]  LED_Groups
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_ss_sync, r_mosi_sync;
  logic        r_sck_d, r_ss_d;
  logic [4:0]  r_bit_cnt;
  logic [30:0] r_rx_shift;
  logic [31:0] r_tx_shift;
  logic        r_tx_from_hold;
  logic        r_hold_valid;
  logic [23:0] r_hold_data;
  logic        r_rd_avail;
  logic [31:0] r_rd_data;
  logic        r_overrun;

  logic w_sck_s, w_ss_s, w_mosi_s;
  logic w_sck_rise, w_sck_fall, w_ss_fall;
  logic w_frame_start, w_bit_sample, w_complete, w_tx_shift;
  logic [31:0] w_rx_full;

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_ss_s     = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s & r_sck_d;
  assign w_ss_fall  = ~w_ss_s & r_ss_d;
  assign w_tx_shift = (r_state == ST_ACTIVE) & w_sck_fall & ~w_ss_s;
  // First wire byte sits in the top of the shift register; it belongs in rd_data[7:0].
  assign w_rx_full  = {r_rx_shift, w_mosi_s};

  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_bit_sample  = 1'b0;
    w_complete    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt   = ST_ACTIVE;
          w_frame_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_ss_s) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sck_rise) begin
          w_bit_sample = 1'b1;
          if (r_bit_cnt == 5'd31) begin
            w_complete  = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (w_ss_s) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_sync     <= '0;
      r_ss_sync      <= '1;
      r_mosi_sync    <= '0;
      r_sck_d        <= 1'b0;
      r_ss_d         <= 1'b1;
      r_state        <= ST_IDLE;
      r_bit_cnt      <= 5'd0;
      r_rx_shift     <= 31'd0;
      r_tx_shift     <= 32'd0;
      r_tx_from_hold <= 1'b0;
      r_hold_valid   <= 1'b0;
      r_hold_data    <= 24'd0;
      r_rd_avail     <= 1'b0;
      r_rd_data      <= 32'd0;
      r_overrun      <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SPI_SCK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SPI_SS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      r_sck_d     <= w_sck_s;
      r_ss_d      <= w_ss_s;
      r_state     <= w_state_nxt;

      if (r_state == ST_IDLE) begin
        r_bit_cnt <= 5'd0;
      end else if (w_bit_sample) begin
        r_bit_cnt  <= r_bit_cnt + 5'd1;
        r_rx_shift <= w_rx_full[30:0];
      end

      // Shift register holds wire order: header byte leaves first, MSB first.
      if (w_frame_start) begin
        r_tx_shift     <= r_hold_valid ?
                          {TX_HDR_BYTE, r_hold_data[7:0], r_hold_data[15:8], r_hold_data[23:16]} :
                          {TX_HDR_BYTE, 24'h0};
        r_tx_from_hold <= r_hold_valid;
      end else if (w_tx_shift) begin
        r_tx_shift <= {r_tx_shift[30:0], 1'b0};
      end

      if (w_complete && r_tx_from_hold) begin
        r_hold_valid <= 1'b0;
      end else if (wr_en && !r_hold_valid) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= wr_data;
      end

      // A completion takes priority over a simultaneous acknowledge.
      if (w_complete) begin
        r_rd_data  <= {w_rx_full[7:0], w_rx_full[15:8], w_rx_full[23:16], w_rx_full[31:24]};
        r_rd_avail <= 1'b1;
        if (r_rd_avail) r_overrun <= 1'b1;
      end else if (rd_ack) begin
        r_rd_avail <= 1'b0;
      end
    end
  end

`ifdef SPI_MISO_TRISTATE_EN
  assign SPI_MISO = w_ss_s ? 1'bz : r_tx_shift[31];
`else
  assign SPI_MISO = w_ss_s ? 1'b0 : r_tx_shift[31];
`endif

  assign wr_buffer_free    = ~r_hold_valid;
  assign rd_data_available = r_rd_avail;
  assign rd_data           = r_rd_data;
  assign LED_Groups        = {r_overrun, r_hold_valid, r_rd_avail, r_state == ST_ACTIVE};

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_four_byte.sv
`default_nettype none
// Testbench for spi_slave_four_byte: mode-0 bus master, vector table and corner-case sequences.
module tb_spi_slave_four_byte;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        SPI_SCK, SPI_SS, SPI_MOSI;
  logic        SPI_MISO;
  logic        wr_buffer_free;
  logic        wr_en;
  logic [23:0] wr_data;
  logic        rd_data_available;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic [3:0]  LED_Groups;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_rd[$];
  logic [31:0] q_tx[$];

  typedef struct {
    logic [31:0] mosi;
    bit          load;
    logic [23:0] wr;
    logic [31:0] exp_miso;
  } vec_t;

  vec_t vecs[4];

  spi_slave_four_byte dut (
    .clk(clk), .reset(reset),
    .SPI_SCK(SPI_SCK), .SPI_SS(SPI_SS), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
    .wr_buffer_free(wr_buffer_free), .wr_en(wr_en), .wr_data(wr_data),
    .rd_data_available(rd_data_available), .rd_ack(rd_ack), .rd_data(rd_data),
    .LED_Groups(LED_Groups)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte k of a word goes out k-th, each byte MSB first; MISO is sampled at SCK rise.
  task automatic spi_frame(input logic [31:0] w, input int nbits, input bit ack_last,
                           input bit keep_low, output logic [31:0] miso_w);
    int idx;
    miso_w = 32'h0;
    SPI_SS = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      idx = 8 * (i / 8) + 7 - (i % 8);
      SPI_MOSI = w[idx];
      clks(HALF);
      miso_w[idx] = SPI_MISO;
      SPI_SCK = 1'b1;
      if (ack_last && i == 31) begin
        clks(2);
        rd_ack = 1'b1;
        clks(1);
        rd_ack = 1'b0;
        clks(HALF - 3);
      end else begin
        clks(HALF);
      end
      SPI_SCK = 1'b0;
    end
    clks(HALF);
    if (!keep_low) begin
      SPI_SS   = 1'b1;
      SPI_MOSI = 1'b0;
      clks(HALF);
    end
  endtask

  task automatic load_tx(input logic [23:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    clks(1);
    wr_en   = 1'b0;
    clks(1);
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    clks(1);
    rd_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] miso_w;
    logic [31:0] exp_w;

    vecs[0] = '{mosi: 32'h0500_0004, load: 1'b0, wr: 24'h0,      exp_miso: 32'h0000_0000};
    vecs[1] = '{mosi: 32'h1234_5678, load: 1'b1, wr: 24'hABCDEF, exp_miso: 32'hABCD_EF00};
    vecs[2] = '{mosi: 32'hDEAD_BEEF, load: 1'b0, wr: 24'h0,      exp_miso: 32'h0000_0000};
    vecs[3] = '{mosi: 32'h8000_0001, load: 1'b1, wr: 24'h5A0FF0, exp_miso: 32'h5A0F_F000};

    reset = 1'b1; SPI_SCK = 1'b0; SPI_SS = 1'b1; SPI_MOSI = 1'b0;
    wr_en = 1'b0; wr_data = 24'h0; rd_ack = 1'b0;
    clks(3);
    chk("reset rd_data", rd_data, 32'h0);
    chk("reset avail", {31'h0, rd_data_available}, 32'h0);
    chk("reset free", {31'h0, wr_buffer_free}, 32'h1);
    chk("reset miso", {31'h0, SPI_MISO}, 32'h0);
    chk("reset leds", {28'h0, LED_Groups}, 32'h0);
    reset = 1'b0;
    clks(4);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].load) begin
        load_tx(vecs[v].wr);
        chk("free after load", {31'h0, wr_buffer_free}, 32'h0);
      end
      q_rd.push_back(vecs[v].mosi);
      q_tx.push_back(vecs[v].exp_miso);
      spi_frame(vecs[v].mosi, 32, 1'b0, 1'b0, miso_w);
      exp_w = q_rd.pop_front();
      chk("vec rd_data", rd_data, exp_w);
      chk("vec avail", {31'h0, rd_data_available}, 32'h1);
      exp_w = q_tx.pop_front();
      chk("vec miso word", miso_w, exp_w);
      chk("vec free after frame", {31'h0, wr_buffer_free}, 32'h1);
      pulse_ack();
      chk("vec avail after ack", {31'h0, rd_data_available}, 32'h0);
      clks(2);
    end

    // Overrun, with rd_ack landing in the completion cycle of the second frame
    spi_frame(32'h1111_1109, 32, 1'b0, 1'b0, miso_w);
    chk("ovr first avail", {31'h0, rd_data_available}, 32'h1);
    chk("ovr led3 clear", {31'h0, LED_Groups[3]}, 32'h0);
    spi_frame(32'h2222_2208, 32, 1'b1, 1'b0, miso_w);
    chk("ovr rd_data", rd_data, 32'h2222_2208);
    chk("ovr avail kept", {31'h0, rd_data_available}, 32'h1);
    chk("ovr led3", {31'h0, LED_Groups[3]}, 32'h1);
    pulse_ack();
    chk("ovr avail after ack", {31'h0, rd_data_available}, 32'h0);
    clks(2);

    // Aborted frame keeps the pending tx word for the next full frame
    load_tx(24'h13579B);
    spi_frame(32'hFFFF_FFFF, 12, 1'b0, 1'b0, miso_w);
    chk("abort avail", {31'h0, rd_data_available}, 32'h0);
    chk("abort rd_data", rd_data, 32'h2222_2208);
    chk("abort free", {31'h0, wr_buffer_free}, 32'h0);
    q_rd.push_back(32'h0000_000A);
    q_tx.push_back(32'h1357_9B00);
    spi_frame(32'h0000_000A, 32, 1'b0, 1'b0, miso_w);
    exp_w = q_rd.pop_front();
    chk("abort next rd_data", rd_data, exp_w);
    exp_w = q_tx.pop_front();
    chk("abort next miso", miso_w, exp_w);
    chk("abort next free", {31'h0, wr_buffer_free}, 32'h1);
    pulse_ack();
    clks(2);

    // Second wr_en while the holding register is full is dropped
    load_tx(24'h246801);
    load_tx(24'h123456);
    spi_frame(32'h0000_0077, 32, 1'b0, 1'b0, miso_w);
    chk("drop miso", miso_w, 32'h2468_0100);
    chk("drop rd_data", rd_data, 32'h0000_0077);

    // Reset in the middle of a frame, with data and a pending tx word present
    load_tx(24'h0F0F0F);
    spi_frame(32'hA5A5_A5A5, 10, 1'b0, 1'b1, miso_w);
    chk("pre-reset frame active", {31'h0, LED_Groups[0]}, 32'h1);
    reset = 1'b1;
    clks(1);
    chk("midreset rd_data", rd_data, 32'h0);
    chk("midreset avail", {31'h0, rd_data_available}, 32'h0);
    chk("midreset free", {31'h0, wr_buffer_free}, 32'h1);
    chk("midreset miso", {31'h0, SPI_MISO}, 32'h0);
    chk("midreset leds", {28'h0, LED_Groups}, 32'h0);
    reset = 1'b0;
    SPI_SS = 1'b1;
    clks(HALF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
